// File: rtl/cpu_micro_pkg.sv
// Shared definitions for the microprogram sequencer: microinstruction field
// positions, branch-select encodings, FSM state type and default vectors.
package cpu_micro_pkg;

    localparam int DEF_AW    = 6;
    localparam int DEF_CW    = 20;
    localparam int NEXT_LSB  = 0;
    localparam int NEXT_MSB  = NEXT_LSB + DEF_AW - 1;
    localparam int CTRL_LSB  = DEF_AW;
    localparam int BS_LSB    = CTRL_LSB;

    localparam logic [1:0] BS_SEQ  = 2'b00;
    localparam logic [1:0] BS_DISP = 2'b01;
    localparam logic [1:0] BS_COND = 2'b10;
    localparam logic [1:0] BS_IRQ  = 2'b11;

    localparam logic [DEF_AW-1:0] DEF_IRQ_VEC   = 6'd48;
    localparam logic [DEF_AW-1:0] DEF_HALT_ADDR = 6'd63;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_HOLD,
        ST_HALT
    } seq_state_e;

endpackage

// File: rtl/micro_next_addr.sv
// Combinational next-micro-address selection from the next-address field,
// branch select, dispatch opcode, zero flag and interrupt request.
module micro_next_addr
    import cpu_micro_pkg::*;
#(
    parameter int               AW      = DEF_AW,
    parameter logic [AW-1:0]    IRQ_VEC = DEF_IRQ_VEC
) (
    input  logic [AW-1:0] next_addr,
    input  logic [1:0]    bs,
    input  logic [3:0]    ir_op,
    input  logic          flag_z,
    input  logic          irq,
    output logic [AW-1:0] nxt
);

    always_comb begin
        nxt = next_addr;
        case (bs)
            BS_SEQ:  nxt = next_addr;
            BS_DISP: nxt = {next_addr[AW-1:4], ir_op};
            // Zero flag only forces bit 0, so odd targets are unconditional.
            BS_COND: nxt = {next_addr[AW-1:1], next_addr[0] | flag_z};
            BS_IRQ:  nxt = irq ? IRQ_VEC : next_addr;
            default: nxt = next_addr;
        endcase
    end

endmodule

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: drives the registered micro-ROM address, gates the
// control field to the datapath and counts retired microinstructions.
//
// state | meaning
// IDLE  | stopped, micro_addr parked at 0
// FETCH | ROM registering the word at micro_addr
// EXEC  | control word presented; commits when not stalled
// HOLD  | single-step pause waiting for step
// HALT  | reached HALT_ADDR, sticky until reset
module micro_sequencer
    import cpu_micro_pkg::*;
#(
    parameter int               AW        = DEF_AW,
    parameter int               CW        = DEF_CW,
    parameter logic [AW-1:0]    IRQ_VEC   = DEF_IRQ_VEC,
    parameter logic [AW-1:0]    HALT_ADDR = DEF_HALT_ADDR,
    parameter int               CNT_W     = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic                single_mode,
    input  logic                step,
    input  logic                stall,
    input  logic [3:0]          ir_op,
    input  logic                flag_z,
    input  logic                irq,
    input  logic [CW+AW-1:0]    micro_op,
    output logic [AW-1:0]       micro_addr,
    output logic [CW-1:0]       ctrl,
    output logic                ctrl_valid,
    output logic                halted,
    output logic [CNT_W-1:0]    uop_cnt
);

    seq_state_e         state_q, state_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]      next_addr;
    logic [1:0]         bs;
    logic [AW-1:0]      nxt;
    logic               exec;

    assign next_addr = micro_op[NEXT_MSB:NEXT_LSB];
    assign bs        = micro_op[BS_LSB +: 2];

    micro_next_addr #(
        .AW      (AW),
        .IRQ_VEC (IRQ_VEC)
    ) u_next_addr (
        .next_addr (next_addr),
        .bs        (bs),
        .ir_op     (ir_op),
        .flag_z    (flag_z),
        .irq       (irq),
        .nxt       (nxt)
    );

    assign exec       = (state_q == ST_EXEC);
    assign ctrl       = exec ? micro_op[CTRL_LSB +: CW] : '0;
    assign ctrl_valid = exec && !stall;
    assign halted     = (state_q == ST_HALT);
    assign micro_addr = addr_q;
    assign uop_cnt    = cnt_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            ST_IDLE: begin
                addr_d = '0;
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                // The word in flight always completes, even if run has dropped.
                if (!stall) begin
                    addr_d = nxt;
                    if (nxt == HALT_ADDR) begin
                        state_d = ST_HALT;
                    end else if (!run) begin
                        state_d = ST_IDLE;
                        addr_d  = '0;
                    end else if (single_mode) begin
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_HOLD: begin
                if (!run) begin
                    state_d = ST_IDLE;
                    addr_d  = '0;
                end else if (step || !single_mode) begin
                    state_d = ST_FETCH;
                end
            end
            ST_HALT: begin
                addr_d = HALT_ADDR;
            end
            default: begin
                state_d = ST_IDLE;
                addr_d  = '0;
            end
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (ctrl_valid && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
